// File: rtl/branch_redirect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
// Shared types for the branch redirect controller:
//   br_type_e   - branch type encodings carried on the br_type request field
//   state_e     - controller FSM states
//   FLUSH_CNT_W - width of the flush down-counter (FLUSH_CYCLES <= 15)
//   bht_update  - 2-bit saturating counter step used by the optional predictor
// -----------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JUMP = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESOLVE  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    localparam int FLUSH_CNT_W = 4;

    // Saturating 2-bit counter: count up on taken, down on not taken.
    function automatic logic [1:0] bht_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_cmp.sv
// -----------------------------------------------------------------------------
// branch_cmp
// Purely combinational branch condition evaluation.
// Ports:
//   br_type  in  3  branch type (br_type_e)
//   rdata1   in  32 first operand
//   rdata2   in  32 second operand
//   taken    out 1  branch outcome
// BR_NONE is never taken, BR_JUMP is always taken.
// -----------------------------------------------------------------------------
module branch_cmp
    import branch_redirect_ctrl_pkg::*;
(
    input  br_type_e    br_type,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        unique case (br_type)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = (rdata1 == rdata2);
            BR_BNE:  taken = (rdata1 != rdata2);
            BR_BLT:  taken = ($signed(rdata1) <  $signed(rdata2));
            BR_BGE:  taken = ($signed(rdata1) >= $signed(rdata2));
            BR_BLTU: taken = (rdata1 <  rdata2);
            BR_BGEU: taken = (rdata1 >= rdata2);
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
// Resolves one branch at a time, compares the outcome with the prediction and,
// on a mispredict, issues a one-cycle fetch redirect followed by FLUSH_CYCLES
// cycles of flush in total.
//
// Parameters:
//   FLUSH_CYCLES  total flush cycles after a redirect (1..15)
//   BHT_ENTRIES   predictor table depth (power of two), used only when
//                 BRANCH_PRED_EN is defined
// Optional feature macro: BRANCH_PRED_EN
//   defined   - internal table of 2-bit counters supplies the prediction,
//               pred_taken is ignored
//   undefined - pred_taken supplies the prediction, no table is built
// Ports:
//   clk, rst_n (sync, active-low)
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   br_type, rdata1, rdata2, pc, target, pred_taken  request fields
//   resolved_valid/resolved_taken  one-cycle outcome pulse
//   redirect_valid/redirect_pc     one-cycle redirect (pc reads 0 otherwise)
//   flush                          kill younger instructions
//   mispredict_cnt                 saturating mispredict counter
// -----------------------------------------------------------------------------
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_ENTRIES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  br_type,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] pc,
    input  logic [31:0] target,
    input  logic        pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        resolved_valid,
    output logic        resolved_taken,
    output logic [15:0] mispredict_cnt
);

    // Elaboration-time parameter sanity checks.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be within 1..15");
    end
    if (BHT_ENTRIES < 2 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_bht_entries
        $error("BHT_ENTRIES must be a power of two >= 2");
    end

    state_e                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    br_type_e               br_type_q, br_type_d;
    logic [31:0]            rdata1_q, rdata1_d;
    logic [31:0]            rdata2_q, rdata2_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            target_q, target_d;
    logic                   pred_q, pred_d;
    logic                   taken_q, taken_d;
    logic [15:0]            mispredict_cnt_q, mispredict_cnt_d;

    logic handshake;
    logic cmp_taken;
    logic pred_at_req;

    assign handshake = req_valid && (state_q == ST_IDLE);

    // Comparison works on the registered request, so the outcome is
    // available in RESOLVE, one cycle after accept.
    branch_cmp u_cmp (
        .br_type (br_type_q),
        .rdata1  (rdata1_q),
        .rdata2  (rdata2_q),
        .taken   (cmp_taken)
    );

`ifdef BRANCH_PRED_EN
    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]           bht_q [BHT_ENTRIES];
    logic [1:0]           bht_d [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] req_idx;
    logic [BHT_IDX_W-1:0] upd_idx;

    // Word-aligned PCs: bits [1:0] carry no information.
    assign req_idx     = pc[BHT_IDX_W+1:2];
    assign upd_idx     = pc_q[BHT_IDX_W+1:2];
    assign pred_at_req = bht_q[req_idx][1];

    always_comb begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (state_q == ST_RESOLVE && br_type_q != BR_NONE) begin
            bht_d[upd_idx] = bht_update(bht_q[upd_idx], cmp_taken);
        end
    end

    // Per-entry registers so every counter can return to weakly not-taken
    // on reset.
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                bht_q[gi] <= 2'b01;
            end else begin
                bht_q[gi] <= bht_d[gi];
            end
        end
    end
`else
    assign pred_at_req = pred_taken;
`endif

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        br_type_d        = br_type_q;
        rdata1_d         = rdata1_q;
        rdata2_d         = rdata2_q;
        pc_d             = pc_q;
        target_d         = target_q;
        pred_d           = pred_q;
        taken_d          = taken_q;
        mispredict_cnt_d = mispredict_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    br_type_d = br_type_e'(br_type);
                    rdata1_d  = rdata1;
                    rdata2_d  = rdata2;
                    pc_d      = pc;
                    target_d  = target;
                    pred_d    = pred_at_req;
                    state_d   = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                taken_d = cmp_taken;
                if (cmp_taken != pred_q) begin
                    state_d = ST_REDIRECT;
                    if (mispredict_cnt_q != 16'hFFFF) begin
                        mispredict_cnt_d = mispredict_cnt_q + 16'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                // REDIRECT itself is the first flush cycle.
                if (FLUSH_CYCLES > 1) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                    flush_cnt_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            flush_cnt_q      <= '0;
            br_type_q        <= BR_NONE;
            rdata1_q         <= '0;
            rdata2_q         <= '0;
            pc_q             <= '0;
            target_q         <= '0;
            pred_q           <= 1'b0;
            taken_q          <= 1'b0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            br_type_q        <= br_type_d;
            rdata1_q         <= rdata1_d;
            rdata2_q         <= rdata2_d;
            pc_q             <= pc_d;
            target_q         <= target_d;
            pred_q           <= pred_d;
            taken_q          <= taken_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    // Outputs are decoded from registered state only, so a reset edge
    // clears all of them on the following cycle.
    assign req_ready      = (state_q == ST_IDLE);
    assign resolved_valid = (state_q == ST_RESOLVE);
    assign resolved_taken = resolved_valid & cmp_taken;
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = redirect_valid ? (taken_q ? target_q : pc_q + 32'd4) : 32'd0;
    assign flush          = (state_q == ST_REDIRECT) || (state_q == ST_FLUSH);
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  br_type;
    logic [31:0] rdata1, rdata2, pc, target;
    logic        pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        resolved_valid;
    logic        resolved_taken;
    logic [15:0] mispredict_cnt;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .BHT_ENTRIES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .br_type        (br_type),
        .rdata1         (rdata1),
        .rdata2         (rdata2),
        .pc             (pc),
        .target         (target),
        .pred_taken     (pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .resolved_valid (resolved_valid),
        .resolved_taken (resolved_taken),
        .mispredict_cnt (mispredict_cnt)
    );

    typedef struct {
        logic [2:0]  bt;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] vpc;
        logic [31:0] tgt;
        logic        pt;
        logic        exp_taken;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic [15:0] exp_cnt;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard queues filled by stimulus, drained by the monitor.
    logic        res_q   [$];
    logic [31:0] redir_q [$];
    int          flen_q  [$];
    int          flush_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the queued expectations.
    always @(negedge clk) begin
        if (resolved_valid === 1'b1) begin
            if (res_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_resolve: got taken=%0b expected no resolution", resolved_taken);
            end else begin
                check("resolved_taken", {31'd0, resolved_taken}, {31'd0, res_q.pop_front()});
            end
        end
        if (redirect_valid === 1'b1) begin
            check("flush_with_redirect", {31'd0, flush}, 32'd1);
            if (redir_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_redirect: got pc=%h expected no redirect", redirect_pc);
            end else begin
                check("redirect_pc", redirect_pc, redir_q.pop_front());
            end
            $display("monitor: redirect pc=%h cnt=%0d", redirect_pc, mispredict_cnt);
        end else begin
            check("redirect_pc_idle", redirect_pc, 32'd0);
        end
        if (flush === 1'b1) begin
            flush_run++;
        end else if (flush_run > 0) begin
            if (flen_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_flush: got %0d cycles expected none", flush_run);
            end else begin
                check("flush_len", flush_run, flen_q.pop_front());
            end
            flush_run = 0;
        end
    end

    function automatic vec_t mk(input logic [2:0] bt, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] vpc, input logic [31:0] tgt, input logic pt,
                                input logic et, input logic er, input logic [31:0] epc,
                                input logic [15:0] ecnt);
        vec_t v;
        v.bt = bt; v.r1 = r1; v.r2 = r2; v.vpc = vpc; v.tgt = tgt; v.pt = pt;
        v.exp_taken = et; v.exp_redir = er; v.exp_pc = epc; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        br_type = v.bt; rdata1 = v.r1; rdata2 = v.r2;
        pc = v.vpc; target = v.tgt; pred_taken = v.pt;
        req_valid = 1'b1;
    endtask

    task automatic push_exp(input vec_t v, input int flen);
        res_q.push_back(v.exp_taken);
        if (v.exp_redir) begin
            redir_q.push_back(v.exp_pc);
            flen_q.push_back(flen);
        end
    endtask

    task automatic wait_ready(input string name);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got req_ready=%b expected 1 within 40 cycles", name, req_ready);
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic issue(input vec_t v, input int idx);
        wait_ready("issue_ready");
        drive(v);
        push_exp(v, FC);
        @(negedge clk);
        req_valid = 1'b0;
        check("resolve_latency", {31'd0, resolved_valid}, 32'd1);
        wait_ready("issue_done");
        check("mispredict_cnt", {16'd0, mispredict_cnt}, {16'd0, v.exp_cnt});
        $display("txn %0d: type=%b r1=%h r2=%h pc=%h exp_taken=%0b exp_redir=%0b cnt=%0d",
                 idx, v.bt, v.r1, v.r2, v.vpc, v.exp_taken, v.exp_redir, mispredict_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [$];
        vec_t v;
        int   hs;

        rst_n = 1'b0; req_valid = 1'b0; br_type = 3'b000;
        rdata1 = '0; rdata2 = '0; pc = '0; target = '0; pred_taken = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_req_ready",      {31'd0, req_ready},      32'd1);
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_flush",          {31'd0, flush},          32'd0);
        check("rst_resolved_valid", {31'd0, resolved_valid}, 32'd0);
        check("rst_mispredict_cnt", {16'd0, mispredict_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef BRANCH_PRED_EN
        //                bt      r1            r2            pc            target        pt  taken redir exp_pc        cnt
        tbl.push_back(mk(3'b001, 32'd5,        32'd5,        32'h0000_0020, 32'h0000_0200, 1, 1, 0, 32'h0,         16'd0));
        tbl.push_back(mk(3'b011, 32'hFFFF_FFFF, 32'd1,       32'h0000_0040, 32'h0000_0100, 0, 1, 1, 32'h0000_0100, 16'd1));
        tbl.push_back(mk(3'b110, 32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0200, 1, 0, 1, 32'h0000_0000, 16'd2));
        tbl.push_back(mk(3'b110, 32'hFFFF_FFFF, 32'd1,       32'h0000_0060, 32'h0000_0200, 1, 1, 0, 32'h0,         16'd2));
        tbl.push_back(mk(3'b010, 32'd3,        32'd3,        32'h0000_0070, 32'h0000_0200, 0, 0, 0, 32'h0,         16'd2));
        tbl.push_back(mk(3'b100, 32'hFFFF_FFFF, 32'd1,       32'h0000_1000, 32'h0000_2000, 1, 0, 1, 32'h0000_1004, 16'd3));
        tbl.push_back(mk(3'b000, 32'd9,        32'd9,        32'h0000_0080, 32'h0000_0800, 1, 0, 1, 32'h0000_0084, 16'd4));
        tbl.push_back(mk(3'b111, 32'd0,        32'd1,        32'h0000_0090, 32'h0000_0300, 0, 1, 1, 32'h0000_0300, 16'd5));
        tbl.push_back(mk(3'b101, 32'd1,        32'hFFFF_FFFF, 32'h0000_00A0, 32'h0000_0400, 1, 1, 0, 32'h0,         16'd5));
        tbl.push_back(mk(3'b010, 32'd7,        32'd8,        32'h0000_00B0, 32'h0000_0500, 1, 1, 0, 32'h0,         16'd5));
        tbl.push_back(mk(3'b001, 32'd1,        32'd2,        32'h0000_0010, 32'h0000_0600, 1, 0, 1, 32'h0000_0014, 16'd6));
        foreach (tbl[i]) issue(tbl[i], i);

        // Back-to-back correct predictions: one accept every two cycles.
        v = mk(3'b001, 32'd5, 32'd5, 32'h0000_0020, 32'h0000_0200, 1, 1, 0, 32'h0, 16'd6);
        drive(v);
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            if (req_ready === 1'b1) begin
                push_exp(v, FC);
                hs++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", hs, 32'd3);
        wait_ready("b2b_done");
        check("b2b_cnt", {16'd0, mispredict_cnt}, 32'd6);
        $display("txn b2b: accepts=%0d", hs);

        // req_valid held through REDIRECT/FLUSH: no accept until IDLE.
        v = mk(3'b011, 32'hFFFF_FFFF, 32'd1, 32'h0000_0040, 32'h0000_0100, 0, 1, 1, 32'h0000_0100, 16'd8);
        drive(v);
        push_exp(v, FC);
        @(negedge clk);
        check("hold_ready_resolve",  {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("hold_ready_redirect", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("hold_ready_flush",    {31'd0, req_ready}, 32'd0);
        check("hold_flush_high",     {31'd0, flush},     32'd1);
        @(negedge clk);
        check("hold_ready_idle",     {31'd0, req_ready}, 32'd1);
        push_exp(v, FC);
        @(negedge clk);
        req_valid = 1'b0;
        wait_ready("hold_done");
        check("hold_cnt", {16'd0, mispredict_cnt}, 32'd8);
        $display("txn hold: cnt=%0d", mispredict_cnt);

        // Reset asserted while in REDIRECT.
        v = mk(3'b011, 32'hFFFF_FFFF, 32'd1, 32'h0000_0040, 32'h0000_0100, 0, 1, 1, 32'h0000_0100, 16'd0);
        drive(v);
        push_exp(v, 1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_redirect", {31'd0, redirect_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("mid_rst_redirect_pc",    redirect_pc,             32'd0);
        check("mid_rst_flush",          {31'd0, flush},          32'd0);
        check("mid_rst_resolved_valid", {31'd0, resolved_valid}, 32'd0);
        check("mid_rst_resolved_taken", {31'd0, resolved_taken}, 32'd0);
        check("mid_rst_cnt",            {16'd0, mispredict_cnt}, 32'd0);
        check("mid_rst_req_ready",      {31'd0, req_ready},      32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset_in_redirect: cnt=%0d", mispredict_cnt);

        issue(mk(3'b010, 32'd1, 32'd2, 32'h0000_0500, 32'h0000_0600, 0, 1, 1, 32'h0000_0600, 16'd1), 100);
`else
        // Predictor build: same pc, unconditional jump three times, then a
        // not-taken BEQ hitting the now strongly-taken entry.
        tbl.push_back(mk(3'b111, 32'd0, 32'd0, 32'h0000_0040, 32'h0000_0400, 0, 1, 1, 32'h0000_0400, 16'd1));
        tbl.push_back(mk(3'b111, 32'd0, 32'd0, 32'h0000_0040, 32'h0000_0400, 0, 1, 0, 32'h0,         16'd1));
        tbl.push_back(mk(3'b111, 32'd0, 32'd0, 32'h0000_0040, 32'h0000_0400, 0, 1, 0, 32'h0,         16'd1));
        tbl.push_back(mk(3'b001, 32'd1, 32'd2, 32'h0000_0040, 32'h0000_0400, 0, 0, 1, 32'h0000_0044, 16'd2));
        foreach (tbl[i]) issue(tbl[i], i);
`endif

        repeat (4) @(negedge clk);
        check("res_queue_empty",   res_q.size(),   32'd0);
        check("redir_queue_empty", redir_q.size(), 32'd0);
        check("flen_queue_empty",  flen_q.size(),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
